// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants and helpers for the AES round datapath.
//   DATA_LEN_DEF : default state width (128 bits, 16 bytes)
//   BYTE_W       : bits per state byte
//   NUM_ROWS     : rows of the 4x4 state matrix
//   NUM_COLS     : columns of the 4x4 state matrix
//   COL_W        : bits per state column (4 bytes)
//   xtime()      : GF(2^8) multiply by {02}, reduction polynomial 0x11B
// State byte k sits at data[127-8k -: 8]; its row is k mod 4 and its
// column is k div 4, so column c occupies data[127-32c -: 32].
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int DATA_LEN_DEF = 128;
    localparam int BYTE_W       = 8;
    localparam int NUM_ROWS     = 4;
    localparam int NUM_COLS     = 4;
    localparam int COL_W        = NUM_ROWS * BYTE_W;

    // Multiply by {02}: shift left, fold the carry back in with 0x1B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        logic [7:0] res;
        res = {a[6:0], 1'b0};
        if (a[7]) begin
            res = res ^ 8'h1B;
        end else begin
            res = res;
        end
        return res;
    endfunction

endpackage : aes_pkg

// File: rtl/shift_mix_stage_mix_column.sv
// ---------------------------------------------------------------------------
// mix_column
// Combinational MixColumns for a single 32-bit column: multiplies the column
// by the circulant matrix {02,03,01,01} over GF(2^8).
//   i_col : input column, byte 0 (row 0) in bits [31:24]
//   o_col : mixed column, same byte ordering
// ---------------------------------------------------------------------------
module mix_column
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] i_col,
    output logic [COL_W-1:0] o_col
);

    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    logic [7:0] w_x0, w_x1, w_x2, w_x3;

    assign w_a0 = i_col[31:24];
    assign w_a1 = i_col[23:16];
    assign w_a2 = i_col[15:8];
    assign w_a3 = i_col[7:0];

    assign w_x0 = xtime(w_a0);
    assign w_x1 = xtime(w_a1);
    assign w_x2 = xtime(w_a2);
    assign w_x3 = xtime(w_a3);

    // {03}*a is xtime(a) ^ a.
    assign o_col[31:24] = w_x0 ^ (w_x1 ^ w_a1) ^ w_a2 ^ w_a3;
    assign o_col[23:16] = w_a0 ^ w_x1 ^ (w_x2 ^ w_a2) ^ w_a3;
    assign o_col[15:8]  = w_a0 ^ w_a1 ^ w_x2 ^ (w_x3 ^ w_a3);
    assign o_col[7:0]   = (w_x0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x3;

endmodule : mix_column

// File: rtl/shift_mix_stage.sv
// ---------------------------------------------------------------------------
// shift_mix_stage
// Two-stage valid/ready pipeline performing AES ShiftRows then MixColumns.
// S1 registers the ShiftRows result; S2 registers MixColumns (or the
// unchanged ShiftRows state when the block is in the final round).
//   clk            : clock, rising edge
//   reset          : synchronous active-high reset
//   valid_in       : input block present
//   ready_out      : stage can accept a block this cycle
//   data_in        : SubBytes output state
//   last_round_in  : final-round flag (bypass MixColumns)
//   valid_out      : output block present
//   ready_in       : downstream accepts the output this cycle
//   data_out       : ShiftRows/MixColumns result
//   last_round_out : final-round flag travelling with the block
// ---------------------------------------------------------------------------
module shift_mix_stage
    import aes_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    output logic                ready_out,
    input  logic [DATA_LEN-1:0] data_in,
    input  logic                last_round_in,
    output logic                valid_out,
    input  logic                ready_in,
    output logic [DATA_LEN-1:0] data_out,
    output logic                last_round_out
);

    logic                r_s1_valid;
    logic [DATA_LEN-1:0] r_s1_data;
    logic                r_s1_last;
    logic                r_s2_valid;
    logic [DATA_LEN-1:0] r_s2_data;
    logic                r_s2_last;

    logic [DATA_LEN-1:0] w_shift;
    logic [DATA_LEN-1:0] w_mix;
    logic [DATA_LEN-1:0] w_s2_next;
    logic                w_s2_load;
    logic                w_s1_load;

    // ShiftRows: output (row r, col c) takes input (row r, col (c+r) mod 4).
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_sr_col
        for (genvar r = 0; r < NUM_ROWS; r++) begin : g_sr_row
            localparam int DST = NUM_ROWS * c + r;
            localparam int SRC = NUM_ROWS * ((c + r) % NUM_COLS) + r;
            assign w_shift[DATA_LEN-1-BYTE_W*DST -: BYTE_W] =
                data_in[DATA_LEN-1-BYTE_W*SRC -: BYTE_W];
        end
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_mix
        mix_column u_mix_column (
            .i_col (r_s1_data[DATA_LEN-1-COL_W*c -: COL_W]),
            .o_col (w_mix[DATA_LEN-1-COL_W*c -: COL_W])
        );
    end

    // S2 can take a new value when it is empty or its content is leaving;
    // S1 can take a new value when it is empty or its content moves to S2.
    assign w_s2_load = !r_s2_valid || ready_in;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign ready_out = w_s1_load;

    // Select MixColumns result or final-round bypass for S2.
    always_comb begin
        w_s2_next = w_mix;
        if (r_s1_last) begin
            w_s2_next = r_s1_data;
        end else begin
            w_s2_next = w_mix;
        end
    end

    // S1 register: ShiftRows result and round flag; data only moves on a real block.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= {DATA_LEN{1'b0}};
            r_s1_last  <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= valid_in;
            if (valid_in) begin
                r_s1_data <= w_shift;
                r_s1_last <= last_round_in;
            end
        end
    end

    // S2 register: MixColumns/bypass result and round flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= {DATA_LEN{1'b0}};
            r_s2_last  <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_s2_next;
                r_s2_last <= r_s1_last;
            end
        end
    end

    assign valid_out      = r_s2_valid;
    assign data_out       = r_s2_data;
    assign last_round_out = r_s2_last;

endmodule : shift_mix_stage

// File: tb/tb_shift_mix_stage.sv
// ---------------------------------------------------------------------------
// tb_shift_mix_stage
// Directed self-checking bench for shift_mix_stage.
// ---------------------------------------------------------------------------
module tb_shift_mix_stage;

    logic         clk;
    logic         reset;
    logic         valid_in;
    logic         ready_out;
    logic [127:0] data_in;
    logic         last_round_in;
    logic         valid_out;
    logic         ready_in;
    logic [127:0] data_out;
    logic         last_round_out;

    int n_tests;
    int n_fail;

    shift_mix_stage #(.DATA_LEN(128)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .data_in        (data_in),
        .last_round_in  (last_round_in),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .data_out       (data_out),
        .last_round_out (last_round_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rows constant across columns, so ShiftRows is the identity; with
    // last=1 the expected output equals the input.
    function automatic logic [127:0] blk(input int i);
        logic [7:0]  b;
        logic [31:0] col;
        b   = 8'(i);
        col = {8'h10 + b, 8'h20 + b, 8'h30 + b, 8'h40 + b};
        return {4{col}};
    endfunction

    // One block through an otherwise idle pipeline with ready_in=1.
    task automatic run_one(input string tag, input logic [127:0] din, input logic lst,
                           input logic [127:0] exp_d, input logic exp_l);
        ready_in      = 1'b1;
        valid_in      = 1'b1;
        data_in       = din;
        last_round_in = lst;
        tick();
        valid_in = 1'b0;
        data_in  = 128'h0;
        check({tag, "_lat1_valid"}, 128'(valid_out), 128'(1'b0));
        tick();
        check({tag, "_valid"}, 128'(valid_out), 128'(1'b1));
        check({tag, "_data"}, data_out, exp_d);
        check({tag, "_last"}, 128'(last_round_out), 128'(exp_l));
        tick();
        check({tag, "_drain"}, 128'(valid_out), 128'(1'b0));
    endtask

    initial begin
        logic [127:0] held;
        int           sent;
        int           got;
        logic         acc;
        logic         outx;

        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        valid_in      = 1'b0;
        data_in       = 128'h0;
        last_round_in = 1'b0;
        ready_in      = 1'b1;

        tick();
        tick();
        check("rst_valid_out", 128'(valid_out), 128'(1'b0));
        check("rst_data_out", data_out, 128'h0);
        check("rst_last_out", 128'(last_round_out), 128'(1'b0));
        reset = 1'b0;
        tick();
        check("post_rst_ready", 128'(ready_out), 128'(1'b1));

        run_one("fips_r1", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0,
                128'h046681e5e0cb199a48f8d37a2806264c, 1'b0);
        run_one("bypass", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1,
                128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1);
        run_one("col_db13", {4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}}, 1'b0);
        run_one("col_f20a", {4{32'hf20a225c}}, 1'b0, {4{32'h9fdc589d}}, 1'b0);
        run_one("col_0101", {4{32'h01010101}}, 1'b0, {4{32'h01010101}}, 1'b0);

        // Backpressure: 6 blocks, ready_in low in cycles 3..7.
        sent = 0;
        got  = 0;
        held = 128'h0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            ready_in      = (cyc >= 3 && cyc <= 7) ? 1'b0 : 1'b1;
            valid_in      = (sent < 6) ? 1'b1 : 1'b0;
            data_in       = blk(sent);
            last_round_in = 1'b1;
            #1;
            if (cyc == 3) begin
                check("bp_ready_low", 128'(ready_out), 128'(1'b0));
                held = data_out;
            end
            if (cyc > 3 && cyc <= 7) begin
                check("bp_hold_data", data_out, held);
                check("bp_hold_valid", 128'(valid_out), 128'(1'b1));
            end
            acc  = valid_in && ready_out;
            outx = valid_out && ready_in;
            if (outx) begin
                check("bp_order", data_out, blk(got));
                check("bp_last", 128'(last_round_out), 128'(1'b1));
                got++;
            end
            if (acc) begin
                sent++;
            end
            tick();
        end
        valid_in = 1'b0;
        check("bp_sent", 128'(sent), 128'(6));
        check("bp_got", 128'(got), 128'(6));
        tick();
        tick();
        check("bp_empty", 128'(valid_out), 128'(1'b0));

        // Reset mid-stream with two blocks held.
        ready_in      = 1'b0;
        valid_in      = 1'b1;
        last_round_in = 1'b1;
        data_in       = blk(20);
        tick();
        data_in = blk(21);
        tick();
        valid_in = 1'b0;
        check("mid_two_held", 128'(ready_out), 128'(1'b0));
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        ready_in = 1'b1;
        #1;
        check("mid_rst_valid", 128'(valid_out), 128'(1'b0));
        check("mid_rst_data", data_out, 128'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mid_no_stale", 128'(valid_out), 128'(1'b0));
        end
        run_one("post_rst", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0,
                128'h046681e5e0cb199a48f8d37a2806264c, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_shift_mix_stage

// File: doc/shift_mix_stage.md
SHIFT_MIX_STAGE -- requirements
Module: shift_mix_stage

Interface
REQ-001 Parameter: DATA_LEN, 128, state width in bits; only 128 is supported.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: valid_in  input  1  data_in/last_round_in carry a block this cycle.
REQ-005 Port: ready_out  output  1  stage accepts a block this cycle.
REQ-006 Port: data_in  input  DATA_LEN  SubBytes output state.
REQ-007 Port: last_round_in  input  1  block is in the final round: skip MixColumns.
REQ-008 Port: valid_out  output  1  data_out/last_round_out hold a result.
REQ-009 Port: ready_in  input  1  downstream (AddRoundKey) accepts the result this cycle.
REQ-010 Port: data_out  output  DATA_LEN  ShiftRows then MixColumns result.
REQ-011 Port: last_round_out  output  1  last_round_in delayed with its block.

Function
REQ-012 Byte order SHALL follow FIPS-197: byte k = data[127-8k -: 8], row k mod 4, column k div 4.
REQ-013 ShiftRows SHALL rotate row r left by r positions (r = 0..3).
REQ-014 MixColumns SHALL multiply each column by circulant {02,03,01,01} over GF(2^8), reduction polynomial 0x11B.
REQ-015 When the block's last_round flag is 1, data_out SHALL equal the ShiftRows result unchanged.
REQ-016 Pipeline SHALL have two register stages: S1 holds the ShiftRows result and flag; S2 holds the MixColumns/bypass result and flag.
REQ-017 A transfer SHALL occur when valid and ready are both 1 on the same edge, on either side.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to valid_out with ready_in held at 1.
REQ-019 Throughput SHALL be one block per cycle with ready_in held at 1.
REQ-020 S2 SHALL load when S2 is empty or ready_in is 1; S1 SHALL load when S1 is empty or S1 moves to S2.
REQ-021 ready_out SHALL be 1 exactly when S1 is empty or S1 advances this cycle (combinational in ready_in; no combinational path from valid_in).
REQ-022 With ready_in at 0 and both stages full, ready_out SHALL be 0 and data_out/last_round_out SHALL hold stable.
REQ-023 Simultaneous input transfer and output transfer with both stages full SHALL advance all blocks with no loss or duplication.
REQ-024 Blocks SHALL leave in arrival order; stage capacity is exactly 2 blocks.
REQ-025 valid_in at 0 SHALL never alter any S1 or S2 data register.

Reset
REQ-026 While reset is 1: valid_out=0, last_round_out=0, data_out=0, internal valid flags cleared, and ready_out=1 from the first cycle after reset is released.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight blocks; no stale block SHALL appear at the output afterwards.
REQ-028 Reset SHALL take effect only at a clock edge; there is no asynchronous term.

Structure
REQ-029 Shared package aes_pkg SHALL hold the DATA_LEN default, the byte/column index constants, and the xtime (GF multiply by 02) function.
REQ-030 Sub-module mix_column (combinational, 32-bit in/out) SHALL be instantiated four times, once per column.
REQ-031 ShiftRows SHALL be pure wiring in front of S1, with no logic.

Verification
REQ-032 FIPS-197 App. B round 1: data_in=d42711aee0bf98f1b8b45de51e415230, last=0 -> data_out=046681e5e0cb199a48f8d37a2806264c after 2 cycles.
REQ-033 Bypass: same data_in with last=1 -> data_out=d4bf5d30e0b452aeb84111f11e2798e5, last_round_out=1.
REQ-034 Column vectors, all four columns db135345, last=0 -> every column of data_out is 8e4da1bc; all columns f20a225c -> 9fdc589d; all columns 01010101 -> unchanged.
REQ-035 Backpressure: stream 6 distinct blocks, ready_in=0 for cycles 3-7 -> ready_out falls after 2 are held, output is stable while stalled, all 6 emerge in order with none lost.
REQ-036 Reset mid-stream: 2 blocks in flight, reset pulsed 1 cycle -> valid_out=0 the next cycle, neither block ever emitted, next input appears 2 cycles after acceptance.
